// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Sequences every main-memory access through the MAR/MBR pair. A fetch
// requester (read-only) and an execute requester (load/store) share one
// memory port. A fixed four-state sequence handles them: IDLE, ADDR, ACCESS, DONE.
// Only one access is in flight at a time. When both requesters ask in the
// same IDLE cycle, a round-robin grant decides which one goes first.
module mem_access_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              f_req_i,
    input  logic [ADDR_W-1:0] f_addr_i,
    output logic              f_ack_o,
    input  logic              e_req_i,
    input  logic              e_we_i,
    input  logic [ADDR_W-1:0] e_addr_i,
    input  logic [DATA_W-1:0] e_wdata_i,
    output logic              e_ack_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] mar_o
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ADDR   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    // Sequencer state
    logic [1:0]        state_q, state_d;
    // Memory address and buffer registers
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mbr_q, mbr_d;
    // 1 = current access belongs to the execute requester
    logic              gnt_exec_q, gnt_exec_d;
    // 1 = most recent grant went to execute (reset value lets fetch win the first tie)
    logic              last_exec_q, last_exec_d;
    // Current access is a store (captured in ADDR together with the address)
    logic              store_q, store_d;
    // Registered acknowledge pulses
    logic              f_ack_q, f_ack_d;
    logic              e_ack_q, e_ack_d;

    // Memory array; contents are deliberately not cleared by reset
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_rdata_s;
    logic              mem_we_s;

    // Arbitration helpers
    logic              any_req_s;
    logic              pick_exec_s;

    // Round-robin pick: the requester that was not granted last wins a tie
    always_comb begin
        any_req_s = f_req_i | e_req_i;
        if (f_req_i && e_req_i) begin
            pick_exec_s = ~last_exec_q;
        end else begin
            pick_exec_s = e_req_i;
        end
    end

    // Read the word addressed by MAR; it is captured into MBR during ACCESS
    always_comb begin
        mem_rdata_s = mem_q[mar_q];
    end

    // Store commits at the end of ACCESS; a reset on that edge cancels the write
    always_comb begin
        if ((state_q == S_ACCESS) && store_q && !rst_i) begin
            mem_we_s = 1'b1;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Next-state logic for the sequencer, MAR/MBR and the acknowledge pulses
    always_comb begin
        state_d     = state_q;
        mar_d       = mar_q;
        mbr_d       = mbr_q;
        gnt_exec_d  = gnt_exec_q;
        last_exec_d = last_exec_q;
        store_d     = store_q;
        f_ack_d     = 1'b0;
        e_ack_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Requests are evaluated fresh every IDLE cycle, so a request
                // still high during DONE is never serviced twice
                if (any_req_s) begin
                    gnt_exec_d  = pick_exec_s;
                    last_exec_d = pick_exec_s;
                    state_d     = S_ADDR;
                end else begin
                    state_d     = S_IDLE;
                end
            end

            S_ADDR: begin
                // Address, direction and store data are sampled only here
                if (gnt_exec_q) begin
                    mar_d   = e_addr_i;
                    store_d = e_we_i;
                    if (e_we_i) begin
                        mbr_d = e_wdata_i;
                    end else begin
                        mbr_d = mbr_q;
                    end
                end else begin
                    mar_d   = f_addr_i;
                    store_d = 1'b0;
                    mbr_d   = mbr_q;
                end
                state_d = S_ACCESS;
            end

            S_ACCESS: begin
                // Reads load MBR; stores leave MBR holding the written data
                if (store_q) begin
                    mbr_d = mbr_q;
                end else begin
                    mbr_d = mem_rdata_s;
                end
                // Ack is registered, so it is decoded here and appears in DONE
                f_ack_d = ~gnt_exec_q;
                e_ack_d = gnt_exec_q;
                state_d = S_DONE;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer registers with synchronous reset that takes priority over everything else
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            mar_q       <= {ADDR_W{1'b0}};
            mbr_q       <= {DATA_W{1'b0}};
            gnt_exec_q  <= 1'b0;
            last_exec_q <= 1'b1;
            store_q     <= 1'b0;
            f_ack_q     <= 1'b0;
            e_ack_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            mar_q       <= mar_d;
            mbr_q       <= mbr_d;
            gnt_exec_q  <= gnt_exec_d;
            last_exec_q <= last_exec_d;
            store_q     <= store_d;
            f_ack_q     <= f_ack_d;
            e_ack_q     <= e_ack_d;
        end
    end

    // Memory write port (no reset: contents survive a controller reset)
    always_ff @(posedge clk_i) begin
        if (mem_we_s) begin
            mem_q[mar_q] <= mbr_q;
        end
    end

    assign f_ack_o = f_ack_q;
    assign e_ack_o = e_ack_q;
    assign rdata_o = mbr_q;
    assign mar_o   = mar_q;
    assign busy_o  = (state_q != S_IDLE);

endmodule
